c_prio_arbiter_aging: RTL and testbench

- Multi-level priority arbiter with per-port starvation aging and optional grant locking. Successor to the plain priority-select plus per-level round-robin arbiter.
- Requests carry an explicit priority:
  - the highest effective level wins;
  - ties within a level rotate round-robin.
- Ports waiting too long escalate to an urgent level above all normal priorities.
- Sits in switch and VC allocators wherever traffic classes must share an output without starving low classes.

---
 rtl/c_prio_arbiter_aging.sv | 193 +++++++++++++++++++
 tb/tb_c_prio_arbiter_aging.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/c_prio_arbiter_aging.sv
// Multi-level priority arbiter: strict priority across levels, round-robin within a level,
// grant locking, and starvation aging to an urgent level when PRIO_AGING_EN is defined.
module c_prio_arbiter_aging #(
    parameter int unsigned NumPorts      = 4,
    parameter int unsigned NumPriorities = 4,
    parameter int unsigned AgeWidth      = 4,
    parameter int unsigned AgeThreshold  = 8,
    localparam int unsigned PrioWidth    = (NumPriorities > 1) ? $clog2(NumPriorities) : 1,
    localparam int unsigned LevelWidth   = $clog2(NumPriorities + 2)
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic                              i_active,
    input  logic                              i_update,
    input  logic [0:NumPorts-1]               i_req,
    input  logic [0:NumPorts*PrioWidth-1]     i_priorities,
    input  logic [0:NumPorts-1]               i_lock,
    output logic [0:NumPorts-1]               o_gnt,
    output logic [LevelWidth-1:0]             o_gnt_level,
    output logic [0:NumPorts-1]               o_starved
);

    localparam int unsigned PtrWidth = $clog2(NumPorts);
`ifdef PRIO_AGING_EN
    localparam int unsigned NumPtrs = NumPriorities + 1;
`else
    localparam int unsigned NumPtrs = NumPriorities;
`endif
    localparam logic [LevelWidth-1:0] UrgentLevel = LevelWidth'(NumPriorities + 1);

    typedef logic [PtrWidth-1:0] ptr_t;

    if (AgeThreshold == 0 || AgeThreshold > (2 ** AgeWidth - 1)) begin : g_bad_threshold
        $error("AgeThreshold must lie in 1..2**AgeWidth-1");
    end

    function automatic ptr_t wrap_add(input ptr_t base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NumPorts) begin
            s = s - NumPorts;
        end
        return ptr_t'(s);
    endfunction

    ptr_t                  r_ptr [NumPtrs];
    logic                  r_hold_valid;
    ptr_t                  r_holder;

    logic [0:NumPorts-1]   w_urgent;
    logic [LevelWidth-1:0] w_level [NumPorts];
    logic [LevelWidth-1:0] w_max_level;
    logic [0:NumPorts-1]   w_set;
    ptr_t                  w_sel_ptr;
    logic                  w_arb_found;
    ptr_t                  w_arb_idx;
    logic                  w_hold_active;
    ptr_t                  w_winner;
    logic                  w_any;
    logic                  w_commit;

    // Effective level per port: 0 idle, p+1 normal, NumPriorities+1 urgent.
    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            if (!i_req[i]) begin
                w_level[i] = '0;
            end else if (w_urgent[i]) begin
                w_level[i] = UrgentLevel;
            end else begin
                w_level[i] = LevelWidth'(i_priorities[i*PrioWidth +: PrioWidth]) + LevelWidth'(1);
            end
        end
    end

    always_comb begin
        w_max_level = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (w_level[i] > w_max_level) begin
                w_max_level = w_level[i];
            end
        end
        for (int i = 0; i < NumPorts; i++) begin
            w_set[i] = i_req[i] && (w_level[i] == w_max_level);
        end
    end

    always_comb begin
        w_sel_ptr = '0;
        for (int l = 0; l < NumPtrs; l++) begin
            if (w_max_level == LevelWidth'(l + 1)) begin
                w_sel_ptr = r_ptr[l];
            end
        end
    end

    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = 0; k < NumPorts; k++) begin
            if (!w_arb_found && w_set[wrap_add(w_sel_ptr, 32'(k))]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = wrap_add(w_sel_ptr, 32'(k));
            end
        end
    end

    assign w_hold_active = r_hold_valid && i_req[r_holder];
    assign w_winner      = w_hold_active ? r_holder : w_arb_idx;
    assign w_any         = w_hold_active || w_arb_found;
    assign w_commit      = i_active && i_update;

    always_comb begin
        o_gnt = '0;
        if (i_reset_n && w_any) begin
            o_gnt[w_winner] = 1'b1;
        end
    end

    assign o_gnt_level = (i_reset_n && w_any) ? w_level[w_winner] : '0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int l = 0; l < NumPtrs; l++) begin
                r_ptr[l] <= '0;
            end
            r_hold_valid <= 1'b0;
            r_holder     <= '0;
        end else if (i_active) begin
            if (i_update) begin
                // A held grant does not advance the round-robin pointer.
                if (w_any && !w_hold_active) begin
                    for (int l = 0; l < NumPtrs; l++) begin
                        if (w_max_level == LevelWidth'(l + 1)) begin
                            r_ptr[l] <= wrap_add(w_arb_idx, 32'd1);
                        end
                    end
                end
                r_hold_valid <= w_any && i_lock[w_winner];
                r_holder     <= w_winner;
            end else if (!w_hold_active) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

`ifdef PRIO_AGING_EN
    logic [AgeWidth-1:0] r_age [NumPorts];
    logic [AgeWidth-1:0] w_age_d [NumPorts];
    logic [0:NumPorts-1] r_starved;
    logic [0:NumPorts-1] w_starved_d;

    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            w_age_d[i] = r_age[i];
            if (w_commit) begin
                if (w_any && (w_winner == ptr_t'(i))) begin
                    w_age_d[i] = '0;
                end else if (i_req[i]) begin
                    if (r_age[i] != {AgeWidth{1'b1}}) begin
                        w_age_d[i] = r_age[i] + AgeWidth'(1);
                    end
                end else begin
                    w_age_d[i] = '0;
                end
            end
            w_starved_d[i] = (w_age_d[i] >= AgeWidth'(AgeThreshold));
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NumPorts; i++) begin
                r_age[i] <= '0;
            end
            r_starved <= '0;
        end else if (i_active) begin
            for (int i = 0; i < NumPorts; i++) begin
                r_age[i] <= w_age_d[i];
            end
            r_starved <= w_starved_d;
        end
    end

    assign w_urgent  = r_starved;
    assign o_starved = r_starved;
`else
    assign w_urgent  = '0;
    assign o_starved = '0;
`endif

    gnt_onehot_a: assert property (@(posedge i_clk) disable iff (!i_reset_n) $onehot0(o_gnt));

endmodule

// File: tb/tb_c_prio_arbiter_aging.sv
// Bench for c_prio_arbiter_aging: vector table driven through a scoreboard queue, plus a
// hand-written asynchronous reset sequence. Expectations follow PRIO_AGING_EN if defined.
module tb_c_prio_arbiter_aging;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       active;
    logic       update;
    logic [0:3] req;
    logic [0:7] prio;
    logic [0:3] lock;
    logic [0:3] gnt;
    logic [2:0] gnt_level;
    logic [0:3] starved;

    always #5 clk = ~clk;

    c_prio_arbiter_aging dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_active     (active),
        .i_update     (update),
        .i_req        (req),
        .i_priorities (prio),
        .i_lock       (lock),
        .o_gnt        (gnt),
        .o_gnt_level  (gnt_level),
        .o_starved    (starved)
    );

    typedef struct {
        logic [3:0] req;
        logic [7:0] prio;
        logic [3:0] lock;
        logic       upd;
        logic       act;
        logic [3:0] gnt;
        logic [2:0] lvl;
        logic [3:0] stv;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [2:0] lvl;
        logic [3:0] stv;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [7:0] pr(input int a, input int b, input int c, input int d);
        return {2'(a), 2'(b), 2'(c), 2'(d)};
    endfunction

    function automatic void add(input logic [3:0] r, input logic [7:0] p, input logic [3:0] lk,
                                input logic u, input logic a, input logic [3:0] g,
                                input logic [2:0] l, input logic [3:0] s);
        vec_t v;
        v.req = r; v.prio = p; v.lock = lk; v.upd = u; v.act = a;
        v.gnt = g; v.lvl = l; v.stv = s;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int i);
        vec_t v;
        exp_t e;
        v = vecs[i];
        @(posedge clk);
        #1;
        req = v.req; prio = v.prio; lock = v.lock; update = v.upd; active = v.act;
        e.gnt = v.gnt; e.lvl = v.lvl; e.stv = v.stv; e.idx = i;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d_gnt", e.idx), {4'b0, gnt}, {4'b0, e.gnt});
            check($sformatf("v%0d_level", e.idx), {5'b0, gnt_level}, {5'b0, e.lvl});
            check($sformatf("v%0d_starved", e.idx), {4'b0, starved}, {4'b0, e.stv});
        end
    endtask

    int seg_a_end;
    logic urg;

    initial begin
        // Level precedence: port 3 highest.
        for (int c = 0; c < 5; c++) add(4'b1111, pr(0, 1, 2, 3), 4'b0, 1, 1, 4'b0001, 3'd4, 4'b0);
        add(4'b0000, pr(0, 0, 0, 0), 4'b0, 1, 1, 4'b0000, 3'd0, 4'b0);
        // Round-robin at level 3, ending with that pointer at 2.
        add(4'b1111, pr(2, 2, 2, 2), 4'b0, 1, 1, 4'b1000, 3'd3, 4'b0);
        add(4'b1111, pr(2, 2, 2, 2), 4'b0, 1, 1, 4'b0100, 3'd3, 4'b0);
        add(4'b1111, pr(2, 2, 2, 2), 4'b0, 1, 1, 4'b0010, 3'd3, 4'b0);
        add(4'b1111, pr(2, 2, 2, 2), 4'b0, 1, 1, 4'b0001, 3'd3, 4'b0);
        add(4'b1111, pr(2, 2, 2, 2), 4'b0, 1, 1, 4'b1000, 3'd3, 4'b0);
        add(4'b1111, pr(2, 2, 2, 2), 4'b0, 1, 1, 4'b0100, 3'd3, 4'b0);
        seg_a_end = vecs.size();
        // After reset: scanning restarts at port 0.
        add(4'b1111, pr(2, 2, 2, 2), 4'b0, 1, 1, 4'b1000, 3'd3, 4'b0);
        add(4'b1111, pr(2, 2, 2, 2), 4'b0, 1, 1, 4'b0100, 3'd3, 4'b0);
        add(4'b0000, pr(0, 0, 0, 0), 4'b0, 1, 1, 4'b0000, 3'd0, 4'b0);
        // Aging: low-priority port 0 against port 1 at priority 3.
        for (int c = 1; c <= 20; c++) begin
`ifdef PRIO_AGING_EN
            urg = (c == 9) || (c == 18);
`else
            urg = 1'b0;
`endif
            add(4'b1100, pr(0, 3, 0, 0), 4'b0, 1, 1, urg ? 4'b1000 : 4'b0100,
                urg ? 3'd5 : 3'd4, urg ? 4'b1000 : 4'b0000);
        end
        add(4'b0000, pr(0, 0, 0, 0), 4'b0, 1, 1, 4'b0000, 3'd0, 4'b0);
        // Lock: port 2 holds against higher-priority port 3.
        add(4'b0010, pr(0, 0, 0, 3), 4'b0010, 1, 1, 4'b0010, 3'd1, 4'b0);
        add(4'b0011, pr(0, 0, 0, 3), 4'b0010, 1, 1, 4'b0010, 3'd1, 4'b0);
        add(4'b0011, pr(0, 0, 0, 3), 4'b0010, 1, 1, 4'b0010, 3'd1, 4'b0);
        add(4'b0011, pr(0, 0, 0, 3), 4'b0010, 0, 1, 4'b0010, 3'd1, 4'b0);
        add(4'b0011, pr(0, 0, 0, 3), 4'b0000, 1, 1, 4'b0010, 3'd1, 4'b0);
        add(4'b0011, pr(0, 0, 0, 3), 4'b0000, 1, 1, 4'b0001, 3'd4, 4'b0);
        // Holder drops req with update=0: hold must be gone afterwards.
        add(4'b0010, pr(0, 0, 0, 3), 4'b0010, 1, 1, 4'b0010, 3'd1, 4'b0);
        add(4'b0001, pr(0, 0, 0, 3), 4'b0000, 0, 1, 4'b0001, 3'd4, 4'b0);
        add(4'b0011, pr(0, 0, 0, 3), 4'b0000, 1, 1, 4'b0001, 3'd4, 4'b0);
        // active=0 must not latch a lock.
        add(4'b0011, pr(0, 0, 0, 3), 4'b0001, 1, 0, 4'b0001, 3'd4, 4'b0);
        add(4'b0011, pr(0, 0, 3, 0), 4'b0000, 1, 1, 4'b0010, 3'd4, 4'b0);

        active = 1'b1; update = 1'b0; req = 4'b1111; prio = pr(2, 2, 2, 2); lock = 4'b0;
        #3;
        check("reset_gnt", {4'b0, gnt}, 8'd0);
        check("reset_level", {5'b0, gnt_level}, 8'd0);
        check("reset_starved", {4'b0, starved}, 8'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < seg_a_end; i++) apply(i);

        // Asynchronous reset while a grant is live.
        @(posedge clk);
        #1;
        req = 4'b1111; prio = pr(2, 2, 2, 2); lock = 4'b0; update = 1'b0; active = 1'b1;
        #2;
        check("pre_reset_gnt", {4'b0, gnt}, 8'b0010);
        reset_n = 1'b0;
        #1;
        check("midrst_gnt", {4'b0, gnt}, 8'd0);
        check("midrst_level", {5'b0, gnt_level}, 8'd0);
        check("midrst_starved", {4'b0, starved}, 8'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = seg_a_end; i < vecs.size(); i++) apply(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
